tag_lookup_unit: RTL and testbench

Set-associative tag lookup and replacement stage for the L2 model.
- Splits an incoming address into tag, index and offset.
- Reads the tag, valid and age state for the indexed set.
- Drives one tag Comparator per way and consumes the match results.
- Returns hit/miss and the selected way, and on allocating misses performs true-LRU victim selection and eviction reporting.
- Sits between the request front end and the data array controller.

---
 rtl/tag_lookup_unit_if.sv | 27 ++
 rtl/tag_lookup_unit.sv | 276 +++++++++++++++++++++++++++
 tb/tb_tag_lookup_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tag_lookup_unit_if.sv
// rtl/tag_lookup_unit_if.sv - request/response bus of the tag lookup stage
interface tag_lookup_unit_if #(
    parameter int addrBits = 22,
    parameter int tagBits  = 12,
    parameter int waysLog2 = 2
);
    logic                req_valid;
    logic                req_ready;
    logic [addrBits-1:0] req_addr;
    logic [1:0]          req_op;
    logic                resp_valid;
    logic                resp_ready;
    logic                resp_hit;
    logic [waysLog2-1:0] resp_way;
    logic                resp_evict_valid;
    logic [tagBits-1:0]  resp_evict_tag;

    modport master (
        output req_valid, req_addr, req_op, resp_ready,
        input  req_ready, resp_valid, resp_hit, resp_way, resp_evict_valid, resp_evict_tag
    );

    modport slave (
        input  req_valid, req_addr, req_op, resp_ready,
        output req_ready, resp_valid, resp_hit, resp_way, resp_evict_valid, resp_evict_tag
    );
endinterface

// File: rtl/tag_lookup_unit.sv
// rtl/tag_lookup_unit.sv - set-associative tag lookup with true-LRU replacement (optional LOOKUP_STATS_EN)
module tag_comparator #(
    parameter int tagBits = 12
) (
    input  logic [tagBits-1:0] stored_tag,
    input  logic [tagBits-1:0] req_tag,
    output logic               match
);
    assign match = (stored_tag == req_tag);
endmodule

module tag_lookup_unit #(
    parameter int tagBits    = 12,
    parameter int indexBits  = 4,
    parameter int offsetBits = 6,
    parameter int waysLog2   = 2
) (
    input  logic        clk,
    input  logic        reset,
    tag_lookup_unit_if.slave bus
`ifdef LOOKUP_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int WAYS = 1 << waysLog2;
    localparam int SETS = 1 << indexBits;

    typedef enum logic [1:0] {IDLE, COMPARE, UPDATE, RESP} state_t;

    state_t                state_q, state_d;
    logic                  rd_done_q, rd_done_d;
    logic [tagBits-1:0]    tag_q, tag_d;
    logic [indexBits-1:0]  index_q, index_d;
    logic [1:0]            op_q, op_d;

    logic [tagBits-1:0]    rd_tag_q [WAYS];
    logic [tagBits-1:0]    rd_tag_d [WAYS];
    logic [WAYS-1:0]       rd_valid_q, rd_valid_d;
    logic [waysLog2-1:0]   rd_age_q [WAYS];
    logic [waysLog2-1:0]   rd_age_d [WAYS];
    logic [WAYS-1:0]       way_hit_q, way_hit_d;
    logic [WAYS-1:0]       match;

    logic                  resp_hit_q, resp_hit_d;
    logic [waysLog2-1:0]   resp_way_q, resp_way_d;
    logic                  resp_evict_valid_q, resp_evict_valid_d;
    logic [tagBits-1:0]    resp_evict_tag_q, resp_evict_tag_d;

    logic [tagBits-1:0]    tag_mem_q   [SETS][WAYS];
    logic [WAYS-1:0]       valid_mem_q [SETS];
    logic [waysLog2-1:0]   age_mem_q   [SETS][WAYS];

    logic                  set_we;
    logic [tagBits-1:0]    set_tag_d [WAYS];
    logic [WAYS-1:0]       set_valid_d;
    logic [waysLog2-1:0]   set_age_d [WAYS];

    logic                  hit_any;
    logic [waysLog2-1:0]   hit_way;
    logic                  has_invalid;
    logic [waysLog2-1:0]   victim;
    logic                  touch_en;
    logic [waysLog2-1:0]   touch_way;

    // The block offset never takes part in a lookup
    logic unused_offset;
    assign unused_offset = ^bus.req_addr[offsetBits-1:0];

    for (genvar w = 0; w < WAYS; w++) begin : g_cmp
        tag_comparator #(.tagBits(tagBits)) u_cmp (
            .stored_tag (rd_tag_q[w]),
            .req_tag    (tag_q),
            .match      (match[w])
        );
    end

    // Next-state, set read, hit resolution, replacement and set write-back
    always_comb begin
        state_d            = state_q;
        rd_done_d          = rd_done_q;
        tag_d              = tag_q;
        index_d            = index_q;
        op_d               = op_q;
        rd_tag_d           = rd_tag_q;
        rd_valid_d         = rd_valid_q;
        rd_age_d           = rd_age_q;
        way_hit_d          = way_hit_q;
        resp_hit_d         = resp_hit_q;
        resp_way_d         = resp_way_q;
        resp_evict_valid_d = resp_evict_valid_q;
        resp_evict_tag_d   = resp_evict_tag_q;
        set_we             = 1'b0;
        set_tag_d          = rd_tag_q;
        set_valid_d        = rd_valid_q;
        set_age_d          = rd_age_q;
        touch_en           = 1'b0;
        touch_way          = '0;

        // Lowest-index hitting way wins if the one-hot invariant is ever broken
        hit_any = |way_hit_q;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_hit_q[w]) hit_way = waysLog2'(w);
        end
        // Prefer the lowest invalid way, otherwise the least recently used one
        has_invalid = ~&rd_valid_q;
        victim      = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (has_invalid) begin
                if (!rd_valid_q[w]) victim = waysLog2'(w);
            end else if (rd_age_q[w] == waysLog2'(WAYS - 1)) begin
                victim = waysLog2'(w);
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    tag_d     = bus.req_addr[offsetBits+indexBits +: tagBits];
                    index_d   = bus.req_addr[offsetBits +: indexBits];
                    op_d      = (bus.req_op == 2'b11) ? 2'b00 : bus.req_op;
                    rd_done_d = 1'b0;
                    state_d   = COMPARE;
                end
            end
            COMPARE: begin
                if (!rd_done_q) begin
                    for (int w = 0; w < WAYS; w++) begin
                        rd_tag_d[w] = tag_mem_q[index_q][w];
                        rd_age_d[w] = age_mem_q[index_q][w];
                    end
                    rd_valid_d = valid_mem_q[index_q];
                    rd_done_d  = 1'b1;
                end else begin
                    way_hit_d = match & rd_valid_q;
                    state_d   = UPDATE;
                end
            end
            UPDATE: begin
                resp_hit_d         = 1'b0;
                resp_way_d         = '0;
                resp_evict_valid_d = 1'b0;
                resp_evict_tag_d   = '0;
                if (hit_any) begin
                    resp_hit_d = 1'b1;
                    resp_way_d = hit_way;
                    set_we     = 1'b1;
                    if (op_q == 2'b10) begin
                        set_valid_d[hit_way] = 1'b0;
                    end else begin
                        touch_en  = 1'b1;
                        touch_way = hit_way;
                    end
                end else if (op_q == 2'b01) begin
                    resp_way_d         = victim;
                    resp_evict_valid_d = rd_valid_q[victim];
                    resp_evict_tag_d   = rd_valid_q[victim] ? rd_tag_q[victim] : '0;
                    set_we             = 1'b1;
                    set_tag_d[victim]  = tag_q;
                    set_valid_d[victim] = 1'b1;
                    touch_en           = 1'b1;
                    touch_way          = victim;
                end
                state_d = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    resp_hit_d         = 1'b0;
                    resp_way_d         = '0;
                    resp_evict_valid_d = 1'b0;
                    resp_evict_tag_d   = '0;
                    state_d            = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // LRU touch: younger ways age by one, touched way becomes youngest
        if (touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (rd_age_q[w] < rd_age_q[touch_way]) set_age_d[w] = rd_age_q[w] + waysLog2'(1);
            end
            set_age_d[touch_way] = '0;
        end
    end

    // State, pipeline and set storage registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= IDLE;
            rd_done_q          <= 1'b0;
            tag_q              <= '0;
            index_q            <= '0;
            op_q               <= '0;
            rd_valid_q         <= '0;
            way_hit_q          <= '0;
            resp_hit_q         <= 1'b0;
            resp_way_q         <= '0;
            resp_evict_valid_q <= 1'b0;
            resp_evict_tag_q   <= '0;
            for (int w = 0; w < WAYS; w++) begin
                rd_tag_q[w] <= '0;
                rd_age_q[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) begin
                valid_mem_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tag_mem_q[s][w] <= '0;
                    age_mem_q[s][w] <= waysLog2'(w);
                end
            end
        end else begin
            state_q            <= state_d;
            rd_done_q          <= rd_done_d;
            tag_q              <= tag_d;
            index_q            <= index_d;
            op_q               <= op_d;
            rd_tag_q           <= rd_tag_d;
            rd_valid_q         <= rd_valid_d;
            rd_age_q           <= rd_age_d;
            way_hit_q          <= way_hit_d;
            resp_hit_q         <= resp_hit_d;
            resp_way_q         <= resp_way_d;
            resp_evict_valid_q <= resp_evict_valid_d;
            resp_evict_tag_q   <= resp_evict_tag_d;
            if (set_we) begin
                valid_mem_q[index_q] <= set_valid_d;
                for (int w = 0; w < WAYS; w++) begin
                    tag_mem_q[index_q][w] <= set_tag_d[w];
                    age_mem_q[index_q][w] <= set_age_d[w];
                end
            end
        end
    end

    assign bus.req_ready        = (state_q == IDLE);
    assign bus.resp_valid       = (state_q == RESP);
    assign bus.resp_hit         = resp_hit_q;
    assign bus.resp_way         = resp_way_q;
    assign bus.resp_evict_valid = resp_evict_valid_q;
    assign bus.resp_evict_tag   = resp_evict_tag_q;

`ifdef LOOKUP_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    // Saturating lookup statistics, counted on the response handshake
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == RESP && bus.resp_ready && op_q != 2'b10) begin
            if (resp_hit_q) begin
                if (hit_count_q != '1) hit_count_d = hit_count_q + 32'd1;
            end else begin
                if (miss_count_q != '1) miss_count_d = miss_count_q + 32'd1;
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif
endmodule

// File: tb/tb_tag_lookup_unit.sv
// tb/tb_tag_lookup_unit.sv - randomized self-checking bench for tag_lookup_unit
module tb_tag_lookup_unit;
    localparam int TAG_BITS = 12;
    localparam int IDX_BITS = 4;
    localparam int OFF_BITS = 6;
    localparam int WL2      = 2;
    localparam int WAYS     = 4;
    localparam int SETS     = 16;
    localparam int ADDR     = 22;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    tag_lookup_unit_if #(.addrBits(ADDR), .tagBits(TAG_BITS), .waysLog2(WL2)) bus ();

`ifdef LOOKUP_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    tag_lookup_unit #(
        .tagBits(TAG_BITS), .indexBits(IDX_BITS), .offsetBits(OFF_BITS), .waysLog2(WL2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef LOOKUP_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference: per-set tags/valids plus a last-use timestamp per way
    logic [TAG_BITS-1:0] m_tag [SETS][WAYS];
    bit                  m_valid [SETS][WAYS];
    int                  m_use [SETS][WAYS];
    int                  use_clock;

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        use_clock = 0;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_tag[s][w]   = '0;
                m_valid[s][w] = 1'b0;
                m_use[s][w]   = -w;
            end
    endtask

    task automatic model_step(input logic [ADDR-1:0] addr, input logic [1:0] op,
                              output logic e_hit, output logic [1:0] e_way,
                              output logic e_ev, output logic [TAG_BITS-1:0] e_evtag);
        int set, hw, v;
        logic [TAG_BITS-1:0] tag;
        logic [1:0] o;
        tag = addr[ADDR-1 -: TAG_BITS];
        set = int'(addr[OFF_BITS +: IDX_BITS]);
        o   = (op == 2'b11) ? 2'b00 : op;
        e_hit = 1'b0; e_way = 2'b00; e_ev = 1'b0; e_evtag = '0;
        hw = -1;
        for (int w = 0; w < WAYS; w++)
            if (hw < 0 && m_valid[set][w] && m_tag[set][w] == tag) hw = w;
        if (hw >= 0) begin
            e_hit = 1'b1;
            e_way = 2'(hw);
            if (o == 2'b10) m_valid[set][hw] = 1'b0;
            else begin use_clock++; m_use[set][hw] = use_clock; end
        end else if (o == 2'b01) begin
            v = -1;
            for (int w = 0; w < WAYS; w++)
                if (v < 0 && !m_valid[set][w]) v = w;
            if (v < 0) begin
                v = 0;
                for (int w = 1; w < WAYS; w++)
                    if (m_use[set][w] < m_use[set][v]) v = w;
            end
            e_way   = 2'(v);
            e_ev    = m_valid[set][v];
            e_evtag = m_valid[set][v] ? m_tag[set][v] : '0;
            m_tag[set][v]   = tag;
            m_valid[set][v] = 1'b1;
            use_clock++;
            m_use[set][v] = use_clock;
        end
    endtask

    task automatic apply_reset();
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.req_op     = 2'b00;
        bus.resp_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic do_req(input logic [ADDR-1:0] addr, input logic [1:0] op, input int hold,
                          output logic o_hit, output logic [1:0] o_way,
                          output logic o_ev, output logic [TAG_BITS-1:0] o_evtag);
        logic e_hit, e_ev;
        logic [1:0] e_way;
        logic [TAG_BITS-1:0] e_evtag;
        int n;
        n = 0;
        while (!bus.req_ready && n < 20) begin @(posedge clk); #1; n++; end
        check_val("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_op    = op;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        model_step(addr, op, e_hit, e_way, e_ev, e_evtag);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.resp_valid && n < 20);
        check_val("latency", n, 3);
        check_val("resp_hit", bus.resp_hit, e_hit);
        check_val("resp_way", bus.resp_way, e_way);
        check_val("evict_valid", bus.resp_evict_valid, e_ev);
        check_val("evict_tag", bus.resp_evict_tag, e_evtag);
        o_hit = bus.resp_hit; o_way = bus.resp_way; o_ev = bus.resp_evict_valid; o_evtag = bus.resp_evict_tag;
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = addr ^ 22'h3FC00;
            bus.req_op    = 2'b01;
            @(posedge clk);
            #1;
            check_val("hold_resp_valid", bus.resp_valid, 1);
            check_val("hold_req_ready", bus.req_ready, 0);
            check_val("hold_hit", bus.resp_hit, e_hit);
            check_val("hold_way", bus.resp_way, e_way);
            check_val("hold_evict", bus.resp_evict_valid, e_ev);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        check_val("post_resp_valid", bus.resp_valid, 0);
        check_val("post_req_ready", bus.req_ready, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic h, ev;
        logic [1:0] way;
        logic [TAG_BITS-1:0] et;
        logic [ADDR-1:0] a;

        apply_reset();
        check_val("rst_req_ready", bus.req_ready, 1);
        check_val("rst_resp_valid", bus.resp_valid, 0);
        check_val("rst_resp_hit", bus.resp_hit, 0);
        check_val("rst_resp_way", bus.resp_way, 0);
        check_val("rst_evict_valid", bus.resp_evict_valid, 0);
        check_val("rst_evict_tag", bus.resp_evict_tag, 0);

        do_req(22'h294C0, 2'b00, 0, h, way, ev, et);
        check_val("t1_hit", h, 0);
        check_val("t1_way", way, 0);
        do_req(22'h294C0, 2'b01, 0, h, way, ev, et);
        check_val("t2_alloc_hit", h, 0);
        check_val("t2_alloc_ev", ev, 0);
        do_req(22'h294C0, 2'b00, 0, h, way, ev, et);
        check_val("t2_lookup_hit", h, 1);
        check_val("t2_lookup_way", way, 0);

        apply_reset();
        for (int i = 1; i <= 5; i++) begin
            a = ADDR'((i << 10) | (3 << 6));
            do_req(a, 2'b01, 0, h, way, ev, et);
            if (i < 5) check_val("fill_way", way, 32'(i - 1));
        end
        check_val("evict_way", way, 0);
        check_val("evict_flag", ev, 1);
        check_val("evict_tag_001", et, 12'h001);
        do_req(22'h004C0, 2'b00, 0, h, way, ev, et);
        check_val("evicted_miss", h, 0);

        do_req(22'h008C0, 2'b00, 5, h, way, ev, et);

        do_req(22'h008C0, 2'b10, 0, h, way, ev, et);
        check_val("inv_hit", h, 1);
        check_val("inv_way", way, 1);
        do_req(22'h008C0, 2'b00, 0, h, way, ev, et);
        check_val("inv_then_miss", h, 0);
        do_req(22'h03CC0, 2'b01, 0, h, way, ev, et);
        check_val("realloc_way", way, 1);
        check_val("realloc_ev", ev, 0);

        bus.req_valid = 1'b1;
        bus.req_addr  = 22'h0C4C0;
        bus.req_op    = 2'b01;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_val("midrst_resp_valid", bus.resp_valid, 0);
        check_val("midrst_req_ready", bus.req_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        do_req(22'h0C4C0, 2'b00, 0, h, way, ev, et);
        check_val("midrst_lookup", h, 0);

        for (int i = 0; i < 250; i++) begin
            logic [TAG_BITS-1:0] t;
            logic [IDX_BITS-1:0] s;
            t = TAG_BITS'($urandom_range(0, 7));
            s = ($urandom_range(0, 3) == 0) ? IDX_BITS'($urandom_range(0, SETS - 1)) : IDX_BITS'(5);
            a = {t, s, OFF_BITS'($urandom)};
            do_req(a, 2'($urandom_range(0, 3)), 0, h, way, ev, et);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
